lif_neuron_array: RTL

Parametrised array of N leaky integrate-and-fire neurons; next generation of our single-threshold IF neuron. Each channel integrates an unsigned input current under a valid strobe, applies optional exponential leak, fires a one-cycle spike when the membrane reaches threshold, then enters a programmable refractory period. Sits between input encoders and downstream neuron layers; its spike vector feeds the next layer's current inputs.

---
 rtl/lif_pkg.sv | 19 +
 rtl/lif_neuron_array_if.sv | 32 +++
 rtl/lif_cell.sv | 102 ++++++++++
 rtl/lif_neuron_array.sv | 68 ++++++
 4 files changed

// File: rtl/lif_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lif_pkg
//  Description : Shared types and constants for the LIF neuron array.
//  Revision    : 1.0 - initial release
// ============================================================================
package lif_pkg;

    typedef enum logic [0:0] {
        INTEGRATE = 1'b0,
        REFRACT   = 1'b1
    } lif_state_t;

    localparam int              c_CNT_W         = 8;
    localparam int              c_DEF_WIDTH     = 16;
    localparam logic [15:0]     c_DEF_THRESHOLD = 16'h8000;

endpackage : lif_pkg
`default_nettype wire

// File: rtl/lif_neuron_array_if.sv
`default_nettype none
// ============================================================================
//  Module      : lif_neuron_array_if
//  Description : Current-in / spike-out bundle plus membrane readout port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lif_neuron_array_if #(
    parameter int N_NEURONS = 4,
    parameter int WIDTH     = 16
) ();

    localparam int c_SEL_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    logic                           in_valid;
    logic [N_NEURONS*WIDTH-1:0]     in_current;
    logic [N_NEURONS-1:0]           spike;
    logic                           out_valid;
    logic [c_SEL_W-1:0]             mem_sel;
    logic [WIDTH-1:0]               mem_out;

    modport master (
        output in_valid, in_current, mem_sel,
        input  spike, out_valid, mem_out
    );

    modport slave (
        input  in_valid, in_current, mem_sel,
        output spike, out_valid, mem_out
    );

endinterface : lif_neuron_array_if
`default_nettype wire

// File: rtl/lif_cell.sv
`default_nettype none
// ============================================================================
//  Module      : lif_cell
//  Description : One leaky integrate-and-fire neuron with refractory counter.
//                Leak is compiled in only when LIF_LEAK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_cell
    import lif_pkg::*;
#(
    parameter int               WIDTH          = c_DEF_WIDTH,
    parameter logic [WIDTH-1:0] THRESHOLD      = WIDTH'(c_DEF_THRESHOLD),
    parameter int               LEAK_SHIFT     = 4,
    parameter int               REFRACT_CYCLES = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_valid,
    input  wire logic [WIDTH-1:0]   i_current,
    output logic                    o_spike,
    output logic [WIDTH-1:0]        o_v
);

`ifdef LIF_LEAK_EN
    localparam bit c_LEAK_EN = 1'b1;
`else
    localparam bit c_LEAK_EN = 1'b0;
`endif

    localparam logic [c_CNT_W-1:0] c_REFRACT = REFRACT_CYCLES[c_CNT_W-1:0];
    localparam logic [c_CNT_W-1:0] c_ONE     = 1;

    lif_state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]       r_v, w_v_nxt;
    logic [c_CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic                   r_spike, w_spike_nxt;

    logic [WIDTH-1:0]       w_leak;
    logic [WIDTH:0]         w_sum;
    logic                   w_fire;

    // Leak never exceeds v, so the subtraction cannot borrow; the extra
    // carry bit keeps a large current from wrapping below threshold.
    assign w_leak = c_LEAK_EN ? (r_v >> LEAK_SHIFT) : '0;
    assign w_sum  = {1'b0, r_v} - {1'b0, w_leak} + {1'b0, i_current};
    assign w_fire = (w_sum >= {1'b0, THRESHOLD});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INTEGRATE;
            r_v     <= '0;
            r_cnt   <= '0;
            r_spike <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_v     <= w_v_nxt;
            r_cnt   <= w_cnt_nxt;
            r_spike <= w_spike_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_v_nxt     = r_v;
        w_cnt_nxt   = r_cnt;
        w_spike_nxt = 1'b0;
        case (r_state)
            INTEGRATE: begin
                if (i_valid) begin
                    if (w_fire) begin
                        w_spike_nxt = 1'b1;
                        w_v_nxt     = '0;
                        if (c_REFRACT != '0) begin
                            w_state_nxt = REFRACT;
                            w_cnt_nxt   = c_REFRACT;
                        end
                    end else begin
                        w_v_nxt = w_sum[WIDTH-1:0];
                    end
                end
            end
            REFRACT: begin
                w_v_nxt   = '0;
                w_cnt_nxt = r_cnt - c_ONE;
                if (r_cnt <= c_ONE) begin
                    w_state_nxt = INTEGRATE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = INTEGRATE;
                w_v_nxt     = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_spike = r_spike;
    assign o_v     = r_v;

endmodule : lif_cell
`default_nettype wire

// File: rtl/lif_neuron_array.sv
`default_nettype none
// ============================================================================
//  Module      : lif_neuron_array
//  Description : N independent LIF neurons, valid-delay flop and membrane
//                readout mux. Leak enabled by defining LIF_LEAK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int               N_NEURONS      = 4,
    parameter int               WIDTH          = c_DEF_WIDTH,
    parameter logic [WIDTH-1:0] THRESHOLD      = WIDTH'(c_DEF_THRESHOLD),
    parameter int               LEAK_SHIFT     = 4,
    parameter int               REFRACT_CYCLES = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    lif_neuron_array_if.slave   bus
);

    localparam int c_SEL_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    logic [N_NEURONS-1:0]   w_spike;
    logic [WIDTH-1:0]       w_v [N_NEURONS];
    logic                   r_out_valid;
    logic [WIDTH-1:0]       w_mem_out;

    for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_cell
        lif_cell #(
            .WIDTH          (WIDTH),
            .THRESHOLD      (THRESHOLD),
            .LEAK_SHIFT     (LEAK_SHIFT),
            .REFRACT_CYCLES (REFRACT_CYCLES)
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .i_valid    (bus.in_valid),
            .i_current  (bus.in_current[gi*WIDTH +: WIDTH]),
            .o_spike    (w_spike[gi]),
            .o_v        (w_v[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
        end
    end

    // Selects outside the populated channels read back as zero.
    always_comb begin
        w_mem_out = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (bus.mem_sel == c_SEL_W'(i)) begin
                w_mem_out = w_v[i];
            end
        end
    end

    assign bus.spike     = w_spike;
    assign bus.out_valid = r_out_valid;
    assign bus.mem_out   = w_mem_out;

endmodule : lif_neuron_array
`default_nettype wire
